// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each requester has a single-entry registered response slot filled one cycle after issue.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [31:0]       issue_count
);

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
  logic              rsp0_zero_q, rsp0_zero_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
  logic              rsp1_zero_q, rsp1_zero_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       issue_count_q, issue_count_d;
  logic              elig0, elig1, grant0, grant1;

  always_comb begin
    // A slot can accept a new result if it is empty or being drained this cycle.
    elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);
    grant0 = elig0 && (!elig1 || last_grant_q);
    grant1 = elig1 && (!elig0 || !last_grant_q);

    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (grant0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_ctrl;
    end else if (grant1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_ctrl;
    end

    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      rsp0_zero_d   = alu_zero;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      rsp1_zero_d   = alu_zero;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    last_grant_d = last_grant_q;
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;

    issue_count_d = issue_count_q + 32'(grant0 || grant1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      last_grant_q  <= 1'b1;
      issue_count_q <= '0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      last_grant_q  <= last_grant_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small MIPS-style ALU model on the alu_* side.
module tb_alu_arbiter;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SLT = 6'b101010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic [5:0]  req0_ctrl;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [5:0]  req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result, issue_count;
  logic [5:0]  alu_control;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      ADD: alu_result = alu_a + alu_b;
      SUB: alu_result = alu_a - alu_b;
      AND: alu_result = alu_a & alu_b;
      OR:  alu_result = alu_a | alu_b;
      XOR: alu_result = alu_a ^ alu_b;
      SLT: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  alu_arbiter #(.DATA_W(32), .CTRL_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .issue_count(issue_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; rsp1_ready = 0;
    tick(); tick();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b%b expected 00", rsp0_valid, rsp1_valid);
    end
    checks++;
    if (rsp0_result !== 32'h0 || rsp1_result !== 32'h0 || rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin
      failures++; $display("FAIL reset_data: got %h %h expected 0 0", rsp0_result, rsp1_result);
    end
    checks++;
    if (issue_count !== 32'h0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", issue_count);
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_control !== 6'h0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL idle_alu: got a=%h b=%h c=%h expected zeros", alu_a, alu_b, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_req0_only();
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = ADD; rsp0_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL req0_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_control !== ADD) begin
      failures++; $display("FAIL req0_alu_mux: got a=%0d b=%0d c=%b expected 5 7 100000", alu_a, alu_b, alu_control);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_zero !== 1'b0) begin
      failures++; $display("FAIL req0_add: got v=%b r=%0d z=%b expected 1 12 0", rsp0_valid, rsp0_result, rsp0_zero);
    end
    checks++;
    if (issue_count !== 32'd1) begin
      failures++; $display("FAIL count_1: got %0d expected 1", issue_count);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd12) begin
      failures++; $display("FAIL req0_drain: got v=%b r=%0d expected 0 12", rsp0_valid, rsp0_result);
    end
  endtask

  task automatic test_req1_only();
    req1_valid = 1; req1_a = 3; req1_b = 3; req1_ctrl = SUB; rsp1_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL req1_grant: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_ctrl = SLT;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd0 || rsp1_zero !== 1'b1) begin
      failures++; $display("FAIL req1_sub: got v=%b r=%0d z=%b expected 1 0 1", rsp1_valid, rsp1_result, rsp1_zero);
    end
    tick();
    req1_valid = 0;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd1 || rsp1_zero !== 1'b0) begin
      failures++; $display("FAIL req1_slt: got v=%b r=%0d z=%b expected 1 1 0", rsp1_valid, rsp1_result, rsp1_zero);
    end
    checks++;
    if (issue_count !== 32'd3) begin
      failures++; $display("FAIL count_3: got %0d expected 3", issue_count);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [31:0] a0[2] = '{32'd10, 32'd100};
    logic [31:0] b0[2] = '{32'd20, 32'd1};
    logic [31:0] r0[2] = '{32'd30, 32'd101};
    logic [31:0] a1[2] = '{32'd50, 32'd9};
    logic [31:0] b1[2] = '{32'd8, 32'd9};
    logic [31:0] r1[2] = '{32'd42, 32'd0};
    logic        z1[2] = '{1'b0, 1'b1};
    int i0 = 0;
    int i1 = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_ctrl = ADD;
    req1_valid = 1; req1_ctrl = SUB;
    for (int k = 0; k < 4; k++) begin
      if (i0 < 2) begin req0_a = a0[i0]; req0_b = b0[i0]; end
      if (i1 < 2) begin req1_a = a1[i1]; req1_b = b1[i1]; end
      #1;
      checks++;
      if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
        failures++; $display("FAIL alt_grant%0d: got r0=%b r1=%b expected %b %b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
      end
      tick();
      if (k % 2 == 0) begin
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== r0[i0]) begin
          failures++; $display("FAIL alt_rsp0_%0d: got v=%b r=%0d expected 1 %0d", k, rsp0_valid, rsp0_result, r0[i0]);
        end
        i0++;
      end else begin
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== r1[i1] || rsp1_zero !== z1[i1]) begin
          failures++; $display("FAIL alt_rsp1_%0d: got v=%b r=%0d z=%b expected 1 %0d %b", k, rsp1_valid, rsp1_result, rsp1_zero, r1[i1], z1[i1]);
        end
        i1++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (issue_count !== 32'd7) begin
      failures++; $display("FAIL count_7: got %0d expected 7", issue_count);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++; $display("FAIL alt_drain: got %b%b expected 00", rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp0_ready = 0; rsp1_ready = 1;
    req0_valid = 1; req0_a = 32'hFF; req0_b = 32'h0F; req0_ctrl = AND;
    req1_valid = 1; req1_a = 0; req1_b = 100; req1_ctrl = ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL bp_first: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_a = 2; req0_b = 2; req0_ctrl = ADD;
    for (int i = 0; i < 3; i++) begin
      req1_a = i;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        failures++; $display("FAIL bp_grant%0d: got r0=%b r1=%b expected 0 1", i, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0F || rsp1_valid !== 1'b1 || rsp1_result !== 32'(100 + i)) begin
        failures++; $display("FAIL bp_hold%0d: got r0=%h r1=%0d expected f %0d", i, rsp0_result, rsp1_result, 100 + i);
      end
    end
    rsp0_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL bp_release: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd4 || issue_count !== 32'd12) begin
      failures++; $display("FAIL bp_after: got v=%b r=%0d cnt=%0d expected 1 4 12", rsp0_valid, rsp0_result, issue_count);
    end
    #1;
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_control !== 6'h0) begin
      failures++; $display("FAIL nogrant_alu: got a=%h b=%h c=%h expected zeros", alu_a, alu_b, alu_control);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F; req0_ctrl = OR;
    tick();
    req0_a = 32'hFF; req0_b = 32'hFF; req0_ctrl = XOR;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hFF || rsp0_zero !== 1'b0) begin
      failures++; $display("FAIL b2b_or: got v=%b r=%h z=%b expected 1 ff 0", rsp0_valid, rsp0_result, rsp0_zero);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0 || rsp0_zero !== 1'b1 || issue_count !== 32'd14) begin
      failures++; $display("FAIL b2b_xor: got v=%b r=%h z=%b cnt=%0d expected 1 0 1 14", rsp0_valid, rsp0_result, rsp0_zero, issue_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp0_ready = 0; rsp1_ready = 1;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = ADD;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_ctrl = ADD;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || req1_ready !== 1'b1) begin
      failures++; $display("FAIL mid_setup: got v0=%b r1=%b expected 1 1", rsp0_valid, req1_ready);
    end
    rst_n = 0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h0 || issue_count !== 32'h0) begin
      failures++; $display("FAIL mid_async: got v=%b r=%h cnt=%0d expected 0 0 0", rsp0_valid, rsp0_result, issue_count);
    end
    tick();
    checks++;
    if (rsp1_valid !== 1'b0 || issue_count !== 32'h0) begin
      failures++; $display("FAIL mid_lost: got v1=%b cnt=%0d expected 0 0", rsp1_valid, issue_count);
    end
    @(negedge clk);
    rst_n = 1;
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 6; req0_b = 6; req0_ctrl = SUB;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL post_reset_rr: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_zero !== 1'b1 || rsp1_valid !== 1'b0 || issue_count !== 32'd1) begin
      failures++; $display("FAIL post_reset_issue: got v0=%b z0=%b v1=%b cnt=%0d expected 1 1 0 1", rsp0_valid, rsp0_zero, rsp1_valid, issue_count);
    end
  endtask

  initial begin
    test_reset();
    test_req0_only();
    test_req1_only();
    test_alternate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU instance between two requesters, such as an execute port and an address/branch-compare port. Each requester uses a valid/ready request channel and a valid/ready response channel. A round-robin arbiter issues at most one operation per cycle to the ALU. The ALU outcome is captured in a single-entry response register per requester, so results appear one cycle after issue.

Parameters:
DATA_W, 32, operand/result width; must equal ALU width.
CTRL_W, 6, ALU function-code width; codes pass through unmodified.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 operation valid
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_W  operand a
req0_b  input  DATA_W  operand b
req0_ctrl  input  CTRL_W  ALU function code
rsp0_valid  output  1  requester 0 result valid
rsp0_ready  input  1  requester 0 consumes result
rsp0_result  output  DATA_W  captured ALU result
rsp0_zero  output  1  captured ALU zero flag
req1_*, rsp1_*  same set as requester 0, for requester 1
alu_a  output  DATA_W  to ALU operand a
alu_b  output  DATA_W  to ALU operand b
alu_control  output  CTRL_W  to ALU function select
alu_result  input  DATA_W  from ALU
alu_zero  input  1  from ALU
issue_count  output  32  total operations issued, wraps at 2^32

Behaviour:
- Reset (async assert, sync release):
  - rsp0_valid, rsp1_valid = 0
  - rsp*_result = 0, rsp*_zero = 0
  - issue_count = 0
  - last_grant = 1, so requester 0 wins the first contention.
- Eligibility: elig_i = req_i_valid && (!rsp_i_valid || rsp_i_ready). A requester is served only if its response slot is empty or drains this same cycle.
- Arbitration, combinational, per cycle:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester != last_grant.
  - Neither eligible: no grant.
- Grant effects:
  - req_i_ready = grant_i. Ready is never asserted without valid.
  - alu_a, alu_b and alu_control are driven from the granted requester's fields.
  - With no grant, all three are driven to 0.
- On a rising edge with grant_i:
  - rsp_i_result <= alu_result
  - rsp_i_zero <= alu_zero
  - rsp_i_valid <= 1
  - last_grant <= i
  - issue_count++
- On a rising edge without grant_i: if rsp_i_valid && rsp_i_ready then rsp_i_valid <= 0; the result and zero registers hold their values.
- Latency and throughput:
  - Request accepted in cycle N gives rsp_i_valid in cycle N+1.
  - Throughput is 1 op/cycle total.
  - A single requester gets 1 op/cycle when its rsp_ready is held at 1.
- Simultaneous drain and grant on the same requester: the new result overwrites, and rsp_i_valid stays 1 with no bubble.
- Backpressure:
  - A held response (rsp_i_ready = 0) blocks only requester i.
  - The other requester is granted every cycle it is valid.
  - last_grant is not updated for a requester that is not granted.
- Protocol obligations:
  - Requesters hold payload stable while valid && !ready.
  - rsp_i_result and rsp_i_zero remain stable while rsp_i_valid && !rsp_i_ready.
- Reset mid-operation: pending responses are discarded immediately, and in-flight grants in that cycle are lost. Requesters must reissue.
- Wrap: issue_count rolls from 0xFFFFFFFF to 0.
- No combinational path from alu_* inputs to any req_*_ready.

Test Plan:
1. Req0 only: a=5, b=7, ctrl=6'b100000 (ADD), rsp0_ready=1 -> req0_ready=1 in cycle N; cycle N+1: rsp0_valid=1, rsp0_result=12, rsp0_zero=0; issue_count=1.
2. Req1 only: a=3, b=3, ctrl=6'b100010 (SUB) -> rsp1_result=0, rsp1_zero=1 one cycle later. Then SLT with a=0xFFFFFFFF, b=1 -> result 1.
3. Both valid continuously, both rsp_ready=1 -> grants alternate 0,1,0,1 starting with req0; 4 ops in 4 cycles; each result matches its own operands.
4. rsp0_ready=0 after first result, both requesting -> rsp0 holds its value stable; req0_ready stays 0; req1 is granted every cycle. Raising rsp0_ready -> req0 is granted that same cycle.
5. Req0 back-to-back (OR 0xF0 | 0x0F, then XOR 0xFF ^ 0xFF) with rsp0_ready=1 -> rsp0_valid held high 2 cycles; results 0xFF, then 0 with zero=1.
6. Assert rst_n=0 while rsp0_valid=1 and req1 is granted -> all rsp_valid=0 and issue_count=0 immediately. After release, the first contention is won by req0.
